uart_tx_param: RTL and testbench



---
 rtl/uart_tx_param.sv | 134 +++++++++++++
 tb/tb_uart_tx_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready handshake and internal baud divider.
// Ports: clk (posedge), reset (sync, active-low), tx_valid/tx_data (producer word, sampled at handshake),
//        tx_ready (accepting, IDLE only), busy (frame in flight), tx (registered serial line, idles high).
// Optional: define UART_TX_PARITY_EN to append a parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              busy,
    output logic              tx
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 1 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_param: illegal parameter value");
    end

    logic [2:0]        state, state_n;
    logic [BW-1:0]     baud, baud_n;
    logic [CW-1:0]     bit_cnt, bit_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              tx_n, last, data_bit;
`ifdef UART_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign last     = baud == '0;
    assign data_bit = LSB_FIRST != 0 ? sh_n[0] : sh_n[DATA_W-1];

    always_comb begin
        state_n = state;
        baud_n  = last ? BAUD_LOAD : baud - BW'(1);
        bit_n   = bit_cnt;
        sh_n    = sh;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                baud_n = BAUD_LOAD;
                if (tx_valid && tx_ready) begin
                    state_n = START;
                    sh_n    = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^tx_data ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: if (last) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA: if (last) begin
                // Shift at the bit boundary so data_bit always reads the next bit to send.
                sh_n = LSB_FIRST != 0 ? sh >> 1 : sh << 1;
                if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                    bit_n = '0;
                end else
                    bit_n = bit_cnt + CW'(1);
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (last) begin
                state_n = STOP;
                bit_n   = '0;
            end
`endif
            STOP: if (last) begin
                if (bit_cnt == LAST_STOP)
                    state_n = IDLE;
                else
                    bit_n = bit_cnt + CW'(1);
            end
            default: state_n = IDLE;
        endcase
        // tx is registered from next-state values so the start bit appears the cycle after handshake.
        tx_n = state_n == START ? 1'b0 :
               state_n == DATA  ? data_bit :
`ifdef UART_TX_PARITY_EN
               state_n == PARITY ? par_n :
`endif
               1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_cnt  <= bit_n;
            sh       <= sh_n;
            tx       <= tx_n;
            busy     <= state_n != IDLE;
            tx_ready <= state_n == IDLE;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: checks two uart_tx_param configurations against a bit-list frame model.
module tb_uart_tx_param;
    localparam int DW0 = 8, CPB0 = 4, ST0 = 2 - 1, LSB0 = 1, PO0 = 0;
    localparam int DW1 = 5, CPB1 = 1, ST1 = 2,     LSB1 = 0, PO1 = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic [7:0] data0 = '0;
    logic [4:0] data1 = '0;
    logic       ready0, busy0, tx0, ready1, busy1, tx1;
    int         vectors = 0;
    int         miscompares = 0;
    logic       exp_q[$];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(DW0), .CLKS_PER_BIT(CPB0), .STOP_BITS(ST0), .LSB_FIRST(LSB0), .PARITY_ODD(PO0)) u0 (
        .clk(clk), .reset(reset), .tx_valid(valid0), .tx_data(data0),
        .tx_ready(ready0), .busy(busy0), .tx(tx0));

    uart_tx_param #(.DATA_W(DW1), .CLKS_PER_BIT(CPB1), .STOP_BITS(ST1), .LSB_FIRST(LSB1), .PARITY_ODD(PO1)) u1 (
        .clk(clk), .reset(reset), .tx_valid(valid1), .tx_data(data1),
        .tx_ready(ready1), .busy(busy1), .tx(tx1));

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [8:0] d);
        if (sel == 1) begin
            valid1 = v;
            data1  = d[4:0];
        end else begin
            valid0 = v;
            data0  = d[7:0];
        end
    endtask

    // Expected tx level for every clock of one frame: start, data, optional parity, stop bits.
    task automatic build(input int sel, input logic [8:0] w);
        int dw, cpb, st, lsb, po;
        logic b, p;
        dw  = sel == 1 ? DW1 : DW0;
        cpb = sel == 1 ? CPB1 : CPB0;
        st  = sel == 1 ? ST1 : ST0;
        lsb = sel == 1 ? LSB1 : LSB0;
        po  = sel == 1 ? PO1 : PO0;
        exp_q.delete();
        p = po[0];
        for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            b = lsb != 0 ? w[i] : w[dw-1-i];
            p ^= b;
            for (int c = 0; c < cpb; c++) exp_q.push_back(b);
        end
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < cpb; c++) exp_q.push_back(p);
`endif
        for (int c = 0; c < st * cpb; c++) exp_q.push_back(1'b1);
    endtask

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, ".tx"},    sel == 1 ? tx1 : tx0, 1'b1);
        chk({tag, ".busy"},  sel == 1 ? busy1 : busy0, 1'b0);
        chk({tag, ".ready"}, sel == 1 ? ready1 : ready0, 1'b1);
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the one IDLE cycle after the frame.
    task automatic frame(input int sel, input logic [8:0] w, input bit keep, input logic [8:0] nw, input bit glitch);
        chk_idle(sel, "pre_idle");
        drive(sel, 1'b1, w);
        @(negedge clk);
        if (keep) drive(sel, 1'b1, nw);
        else drive(sel, 1'b0, 9'($urandom));
        build(sel, w);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("tx[%0d] w=%h", k, w), sel == 1 ? tx1 : tx0, exp_q[k]);
            chk("busy_in_frame", sel == 1 ? busy1 : busy0, 1'b1);
            chk("ready_in_frame", sel == 1 ? ready1 : ready0, 1'b0);
            if (glitch && k == 10) drive(sel, 1'b1, 9'h03C);
            if (glitch && k == 11) drive(sel, 1'b0, 9'($urandom));
            @(negedge clk);
        end
        chk_idle(sel, "post_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] w, nxt;
        bit keep;
        repeat (3) @(negedge clk);
        chk("rst.tx0", tx0, 1'b1);
        chk("rst.busy0", busy0, 1'b0);
        chk("rst.ready0", ready0, 1'b0);
        chk("rst.tx1", tx1, 1'b1);
        chk("rst.ready1", ready1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_idle(0, "rel0");
        chk_idle(1, "rel1");

        frame(0, 9'h0A5, 0, 9'h0, 0);
        frame(0, 9'h000, 1, 9'h0FF, 0);
        frame(0, 9'h0FF, 0, 9'h0, 0);
        frame(0, 9'h0C3, 0, 9'h0, 1);
        repeat (3) begin
            @(negedge clk);
            chk_idle(0, "ignored_3c");
        end

        drive(0, 1'b1, 9'h055);
        @(negedge clk);
        drive(0, 1'b0, 9'h0AA);
        build(0, 9'h055);
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("rst_frame tx[%0d]", k), tx0, exp_q[k]);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.tx", tx0, 1'b1);
        chk("midrst.busy", busy0, 1'b0);
        chk("midrst.ready", ready0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_idle(0, "midrst_rel");
        frame(0, 9'h00F, 0, 9'h0, 0);

        frame(1, 9'h013, 0, 9'h0, 0);

        for (int s = 0; s < 2; s++) begin
            w = 9'($urandom);
            for (int i = 0; i < 12; i++) begin
                nxt  = 9'($urandom);
                keep = i < 11 && $urandom_range(0, 1) == 1;
                frame(s, w, keep, nxt, 0);
                w = nxt;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
